// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU-side types: the word type, the RAM status encoding, and the
// request arbiter's state encoding and default tuning constants.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Consecutive d-side grants tolerated while an i-side fetch is waiting.
    localparam int ARB_STARVE_LIM = 4;
    // Grant cycles allowed before the optional watchdog declares a fault.
    localparam int ARB_TIMEOUT    = 32;

endpackage

// File: rtl/ram_request_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_request_arbiter_if
// Bundles the i-side request, d-side request and RAM request port signals.
//   master : the arbiter's view (takes requests, drives the RAM port)
//   slave  : the environment's view (requesters plus the RAM itself)
//
// Handshake: a requester raises its enable (iREN / dREN / dWEN) with address
// and data, and holds it until its wait line drops low for one cycle. That
// low cycle is the completion cycle; the load word is valid only then.
// Dropping the enable before completion abandons the request.
// ---------------------------------------------------------------------------
interface ram_request_arbiter_if;
    import cpu_types_pkg::*;

    // i-side
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    // d-side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    // RAM port
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/arb_watchdog.sv
// ---------------------------------------------------------------------------
// arb_watchdog
// Loadable up-counter that saturates at 'limit'.
//   CLK, RST  : clock, asynchronous active-high reset
//   clr       : synchronous clear to zero (highest priority)
//   load      : load 'load_val'
//   en        : count up by one (stops at 'limit')
//   limit     : saturation / expiry value
//   expired   : high while count >= limit
// ---------------------------------------------------------------------------
module arb_watchdog #(
    parameter int W = 6
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count < limit)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/ram_request_arbiter.sv
// ---------------------------------------------------------------------------
// ram_request_arbiter
// Arbitrates i-side fetches and d-side loads/stores onto the single RAM
// request port. The granted address/data/op are held in a grant register
// until the RAM reports ACCESS; a RELEASE cycle follows every grant.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous active-high reset
//   bus        ram_request_arbiter_if.master (requesters + RAM port)
//   err        sticky fault flag (RAM ERROR, or watchdog expiry)
//   dbg_state  current arbiter state
//
// Build option: define RAM_ARB_TIMEOUT_EN to add a grant watchdog that
// forces RELEASE and sets err after TIMEOUT grant cycles without ACCESS.
// ---------------------------------------------------------------------------
module ram_request_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIM = ARB_STARVE_LIM
`ifdef RAM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = ARB_TIMEOUT
`endif
) (
    input  logic                         CLK,
    input  logic                         RST,
    ram_request_arbiter_if.master        bus,
    output logic                         err,
    output arb_state_t                   dbg_state
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    arb_state_t    state;
    logic [SW-1:0] starve;
    word_t         g_addr;
    word_t         g_store;
    logic          g_wen;
    logic          ren_q;
    logic          wen_q;
    logic          err_q;

    logic d_req;
    logic starved;
    logic pick_d;
    logic pick_i;
    logic granted;
    logic granted_req;
    logic done;
    logic fault;
    logic timeout;

    assign d_req   = bus.dREN | bus.dWEN;
    // i-side has waited through STARVE_LIM d-grants: it wins this round.
    assign starved = bus.iREN && (starve >= SW'(STARVE_LIM));
    assign pick_d  = (state == IDLE) && d_req && !starved;
    assign pick_i  = (state == IDLE) && !pick_d && bus.iREN;

    assign granted     = (state == GRANT_I) || (state == GRANT_D);
    // A grant stays alive only while its requester still asserts an enable;
    // a dropped enable is an abort and suppresses the wait pulse.
    assign granted_req = (state == GRANT_I) ? bus.iREN : d_req;
    assign fault       = granted && (bus.ramstate == ERROR);
    assign done        = granted && granted_req && (bus.ramstate == ACCESS);

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic wd_expired;

    // Loaded to zero on grant entry; expiry marks the TIMEOUT-th grant cycle.
    arb_watchdog #(.W(TW)) u_watchdog (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (state == RELEASE),
        .load     (pick_d | pick_i),
        .load_val ('0),
        .en       (granted),
        .limit    (TW'(TIMEOUT - 1)),
        .expired  (wd_expired)
    );

    assign timeout = granted && granted_req && wd_expired && !done;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            starve  <= '0;
            g_addr  <= '0;
            g_store <= '0;
            g_wen   <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.iREN) begin
                        starve <= '0;
                    end
                    if (pick_d) begin
                        state   <= GRANT_D;
                        g_addr  <= bus.daddr;
                        g_store <= bus.dstore;
                        g_wen   <= bus.dWEN;
                        ren_q   <= !bus.dWEN;
                        wen_q   <= bus.dWEN;
                        if (bus.iREN && (starve < SW'(STARVE_LIM))) begin
                            starve <= starve + SW'(1);
                        end
                    end else if (pick_i) begin
                        state   <= GRANT_I;
                        g_addr  <= bus.iaddr;
                        g_store <= '0;
                        g_wen   <= 1'b0;
                        ren_q   <= 1'b1;
                        wen_q   <= 1'b0;
                        starve  <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (fault || timeout) begin
                        err_q <= 1'b1;
                    end
                    if (fault || timeout || done || !granted_req) begin
                        state <= RELEASE;
                        ren_q <= 1'b0;
                        wen_q <= 1'b0;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Wait lines and load words are combinational in the completion cycle.
    assign bus.iwait    = !(done && (state == GRANT_I));
    assign bus.dwait    = !(done && (state == GRANT_D));
    assign bus.iload    = (done && (state == GRANT_I)) ? bus.ramload : '0;
    assign bus.dload    = (done && (state == GRANT_D) && !g_wen) ? bus.ramload : '0;

    assign bus.ramREN   = ren_q;
    assign bus.ramWEN   = wen_q;
    assign bus.ramaddr  = g_addr;
    assign bus.ramstore = g_store;

    assign err       = err_q;
    assign dbg_state = state;

endmodule
